// File: rtl/inst_fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch front end.
package inst_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // FETCH is normal operation; HALT is entered on a misaligned redirect and left only by reset.
  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StHalt  = 1'b1
  } fetchState_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetchEntry_t;

  function automatic logic isMisaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response, execute redirect, decoder handoff.
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;
  logic            misalign_err;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_pc_plus4,
    input  inst_ready,
    output misalign_err
  );

  // Memory / execute / decoder side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_pc_plus4,
    output inst_ready,
    input  misalign_err
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous instruction buffer holding {pc, inst}; flush empties it in one cycle.
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetchEntry_t                  pushData,
  input  logic                         pop,
  output logic                         headValid,
  output fetchEntry_t                  headData,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetchEntry_t     mem_q [Depth];
  logic [PtrW-1:0] rdPtr_q;
  logic [PtrW-1:0] wrPtr_q;
  logic [CntW-1:0] count_q;
  logic            popEff;
  logic            full;

  // A pop on an empty buffer is ignored, so push+pop on empty is a plain push.
  always_comb begin
    popEff = pop && (count_q != '0);
    full   = (count_q == CntW'(Depth));
  end

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PtrW'(1);
      end
      if (popEff) begin
        rdPtr_q <= rdPtr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(popEff);
    end
  end

  // Storage array; no reset needed since count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wrPtr_q] <= pushData;
    end
  end

  // Upstream credit accounting must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && full && !popEff));
    end
  end

  assign headValid = (count_q != '0);
  assign headData  = mem_q[rdPtr_q];
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order fetch, wrong-path drop, buffer.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     MAX_OUTST  = 2
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned OutstW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  fetchState_e       state_q;
  logic [XLEN-1:0]   fetchPc_q;
  logic [XLEN-1:0]   rspPc_q;
  logic [OutstW-1:0] outst_q;
  logic [OutstW-1:0] drop_q;
  logic              misalign_q;

  logic [CntW-1:0]   fifoCount;
  logic              headValid;
  fetchEntry_t       headData;
  fetchEntry_t       pushData;

  logic [31:0]       inFlight;
  logic              reqValid;
  logic              reqFire;
  logic              rspFire;
  logic              redirect;
  logic              dropping;
  logic              push;
  logic              pop;
  logic              flush;
  logic              instValid;
  logic [OutstW-1:0] outstNext;

  // Credit check, handshake decode and buffer control for this cycle.
  always_comb begin
    inFlight  = 32'(fifoCount) + 32'(outst_q);
    reqValid  = rst_n && (state_q == StFetch) && (32'(outst_q) < MAX_OUTST) &&
                (inFlight < FIFO_DEPTH);
    reqFire   = reqValid && bus.imem_req_ready;
    rspFire   = bus.imem_rsp_valid;
    redirect  = bus.redirect_valid && (state_q == StFetch);
    outstNext = outst_q + OutstW'(reqFire) - OutstW'(rspFire);
    dropping  = rspFire && (drop_q != '0);
    // A response landing in a redirect cycle belongs to the old path.
    push      = rspFire && !dropping && (state_q == StFetch) && !redirect;
    instValid = rst_n && headValid && (state_q == StFetch);
    pop       = instValid && bus.inst_ready;
    flush     = redirect || (state_q == StHalt);
    pushData  = '{pc: rspPc_q, inst: bus.imem_rsp_data};
  end

  // Fetch FSM with PC, response-PC, outstanding and drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      fetchPc_q  <= RESET_PC;
      rspPc_q    <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      outst_q <= outstNext;
      if (redirect) begin
        // Everything still in flight after this edge is wrong-path.
        drop_q    <= outstNext;
        fetchPc_q <= bus.redirect_pc;
        rspPc_q   <= bus.redirect_pc;
        if (isMisaligned(bus.redirect_pc)) begin
          state_q    <= StHalt;
          misalign_q <= 1'b1;
        end
      end else begin
        if (reqFire) begin
          fetchPc_q <= fetchPc_q + PC_STEP;
        end
        if (dropping) begin
          drop_q <= drop_q - OutstW'(1);
        end
        if (push) begin
          rspPc_q <= rspPc_q + PC_STEP;
        end
      end
    end
  end

  inst_fetch_unit_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pushData  (pushData),
    .pop       (pop),
    .headValid (headValid),
    .headData  (headData),
    .count     (fifoCount)
  );

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc_q;
  assign bus.inst_valid     = instValid;
  assign bus.inst           = headData.inst;
  assign bus.inst_pc        = headData.pc;
  assign bus.inst_pc_plus4  = headData.pc + PC_STEP;
  assign bus.misalign_err   = rst_n && misalign_q;

endmodule
